// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative HI/LO multiply/divide unit (mult, multu, div, divu, mthi, mtlo).
// One shift-add or restoring-divide step per cycle on operand magnitudes, then a sign fix.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cancel,
   input  logic             wr_hi,
   input  logic             wr_lo,
   input  logic [WIDTH-1:0] wr_data,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d, prod;
   logic [WIDTH-1:0]   opnd_q, opnd_d, hi_q, hi_d, lo_q, lo_d;
   logic [WIDTH-1:0]   mag_a, mag_b, rem_n, quo, rem;
   logic [WIDTH:0]     mul_sum, rem_s;
   logic               is_div_q, is_div_d, neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
   logic               dz_q, dz_d, done_q, done_d, sgn, ge;
   // acc holds {product_hi, multiplier} for multiply and {remainder, dividend/quotient} for divide
   always_comb begin
      sgn       = ~op[0];
      mag_a     = (sgn && a[WIDTH-1]) ? -a : a;
      mag_b     = (sgn && b[WIDTH-1]) ? -b : b;
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, acc_q[0] ? opnd_q : {WIDTH{1'b0}}};
      rem_s     = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      ge        = rem_s >= {1'b0, opnd_q};
      rem_n     = ge ? rem_s[WIDTH-1:0] - opnd_q : rem_s[WIDTH-1:0];
      prod      = neg_quo_q ? -acc_q : acc_q;
      quo       = neg_quo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      rem       = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      opnd_d    = opnd_q;
      is_div_d  = is_div_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      dz_d      = dz_q;
      done_d    = 1'b0;
      hi_d      = wr_hi ? wr_data : hi_q;
      lo_d      = wr_lo ? wr_data : lo_q;
      if (cancel) begin
         state_d = IDLE;
      end else if (state_q == IDLE && start) begin
         state_d   = RUN;
         cnt_d     = '0;
         is_div_d  = op[1];
         neg_quo_d = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
         neg_rem_d = sgn & a[WIDTH-1];
         dz_d      = op[1] && b == '0;
         opnd_d    = op[1] ? mag_b : mag_a;
         acc_d     = {{WIDTH{1'b0}}, op[1] ? mag_a : mag_b};
      end else if (state_q == RUN) begin
         acc_d   = is_div_q ? {rem_n, acc_q[WIDTH-2:0], ge} : {mul_sum, acc_q[WIDTH-1:1]};
         cnt_d   = cnt_q + CW'(1);
         state_d = (cnt_q == CW'(WIDTH-1)) ? FIX : RUN;
      end else if (state_q == FIX) begin
         state_d = IDLE;
         done_d  = 1'b1;
         hi_d    = is_div_q ? rem : prod[2*WIDTH-1:WIDTH];
         lo_d    = is_div_q ? (dz_q ? {WIDTH{1'b1}} : quo) : prod[WIDTH-1:0];
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         opnd_q    <= '0;
         is_div_q  <= 1'b0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dz_q      <= 1'b0;
         done_q    <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         opnd_q    <= opnd_d;
         is_div_q  <= is_div_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         dz_q      <= dz_d;
         done_q    <= done_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end
   assign busy = state_q != IDLE;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;
endmodule
